load_store_unit: RTL

Data-memory access engine for the RISC-V core. It sits between the decode/execute stages and data memory and turns the decoder's `MemWrite`/`Store`/`Load` codes into sequenced memory transactions:
- word-aligned address, byte enables and lane-shifted write data out;
- sign/zero-extended load results back.

It stalls the pipeline for the length of each transaction. It flags misaligned accesses and memory timeouts instead of issuing or hanging.

---
 rtl/riscv_pkg.sv | 77 +++++++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared decode constants and load/store unit types for the RISC-V core.
// Pure declarations: no latency; no backpressure.
// Store/load codes are shared with main_decoder.
package riscv_pkg;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    // Everything about an accepted access that must stay stable until it finishes.
    typedef struct packed {
        logic        we;
        logic [2:0]  load;
        logic [1:0]  offset;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic access_misaligned(input logic       we,
                                               input logic [1:0] st,
                                               input logic [2:0] ld,
                                               input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (st)
                STORE_SB: bad = 1'b0;
                STORE_SH: bad = off[0];
                STORE_SW: bad = (off != 2'b00);
                default:  bad = 1'b1;
            endcase
        end else begin
            case (ld)
                LOAD_LB, LOAD_LBU: bad = 1'b0;
                LOAD_LH, LOAD_LHU: bad = off[0];
                LOAD_LW:           bad = (off != 2'b00);
                default:           bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    // Size field is bits [1:0] of either code: 00 byte, 01 half, 10 word.
    function automatic logic [3:0] access_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] wd);
        logic [31:0] d;
        case (st)
            STORE_SB: d = {4{wd[7:0]}};
            STORE_SH: d = {2{wd[15:0]}};
            default:  d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a memory read word.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own valid.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (offset)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase

        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (load)
            LOAD_LB:  data = {{24{lane_b[7]}}, lane_b};
            LOAD_LBU: data = {24'h0, lane_b};
            LOAD_LH:  data = {{16{lane_h[15]}}, lane_h};
            LOAD_LHU: data = {16'h0, lane_h};
            LOAD_LW:  data = rdata;
            default:  data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access engine: sequences one load/store per instruction onto the dmem bus.
// Latency: store done 2 cycles after accept, load 3 (best case); bus_err after TIMEOUT cycles.
// Backpressure: holds dmem_req until dmem_gnt and stalls the pipeline until the done cycle.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [1:0]        store,
    input  logic [2:0]        load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    // Counter holds the number of REQ+WAIT cycles already spent before this one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    lsu_req_t    req_q;
    lsu_req_t    next_req;
    logic [7:0]  cnt;
    logic        aligned;
    logic        expired;
    logic [31:0] ext_data;

    assign aligned = !access_misaligned(lsu_we, store, load, addr[1:0]);
    assign expired = (cnt >= CNT_LAST);

    always_comb begin
        next_req        = '0;
        next_req.we     = lsu_we;
        next_req.load   = load;
        next_req.offset = addr[1:0];
        next_req.be     = access_be(lsu_we ? store : load[1:0], addr[1:0]);
        next_req.wdata  = store_wdata(store, wdata);
    end

    assign stall = !reset && (((state == IDLE) && lsu_valid && aligned) ||
                              (state == REQ) || (state == WAIT));

    assign dmem_we    = req_q.we;
    assign dmem_be    = req_q.be;
    assign dmem_wdata = req_q.wdata;

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (req_q.offset),
        .load   (req_q.load),
        .data   (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_addr  <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            load_data  <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        if (aligned) begin
                            req_q     <= next_req;
                            dmem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            dmem_req  <= 1'b1;
                            cnt       <= '0;
                            state     <= REQ;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    // A grant on the expiry cycle still counts as accepted.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (req_q.we) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (expired) begin
                        dmem_req  <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                        state     <= DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (dmem_rvalid) begin
                        load_data <= ext_data;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (expired) begin
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
